// File: rtl/mips_cpu_divider_if.sv
// rtl/mips_cpu_divider_if.sv - request/result bundle between the CPU HI/LO path and the divider
interface mips_cpu_divider_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             sign;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, sign, a, b,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, sign, a, b,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/mips_cpu_divider.sv
// rtl/mips_cpu_divider.sv - radix-2 restoring divider for MIPS DIV/DIVU
// Divides magnitudes over WIDTH steps, then applies sign correction in one FIX cycle.
module mips_cpu_divider #(
  parameter int WIDTH = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  mips_cpu_divider_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_dvs;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dz;
  logic             r_done;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_div_by_zero;

  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;
  logic             w_last;

  assign w_abs_a = (bus.sign && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign w_abs_b = (bus.sign && bus.b[WIDTH-1]) ? -bus.b : bus.b;

  // Restored remainder is always below the divisor, so only the shifted value needs WIDTH+1 bits.
  assign w_shift = {r_rem, r_q[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, r_dvs});
  assign w_diff  = w_shift[WIDTH-1:0] - r_dvs;
  assign w_last  = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_CALC;
      S_CALC:  if (w_last) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt         <= '0;
      r_rem         <= '0;
      r_q           <= '0;
      r_dvs         <= '0;
      r_neg_q       <= 1'b0;
      r_neg_r       <= 1'b0;
      r_dz          <= 1'b0;
      r_done        <= 1'b0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_div_by_zero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_cnt   <= '0;
            r_rem   <= '0;
            r_q     <= w_abs_a;
            r_dvs   <= w_abs_b;
            r_neg_q <= bus.sign & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            r_neg_r <= bus.sign & bus.a[WIDTH-1];
            r_dz    <= (bus.b == '0);
          end
        end
        S_CALC: begin
          r_rem <= w_ge ? w_diff : w_shift[WIDTH-1:0];
          r_q   <= {r_q[WIDTH-2:0], w_ge};
          r_cnt <= r_cnt + 1'b1;
        end
        S_FIX: begin
          r_quotient    <= r_neg_q ? -r_q : r_q;
          r_remainder   <= r_neg_r ? -r_rem : r_rem;
          r_div_by_zero <= r_dz;
          r_done        <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (r_state != S_IDLE);
  assign bus.done        = r_done;
  assign bus.quotient    = r_quotient;
  assign bus.remainder   = r_remainder;
  assign bus.div_by_zero = r_div_by_zero;
endmodule

// File: tb/tb_mips_cpu_divider.sv
// tb/tb_mips_cpu_divider.sv - vector, corner-sequence and randomized checks of mips_cpu_divider
module tb_mips_cpu_divider;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  mips_cpu_divider_if #(.WIDTH(32)) dif();

  mips_cpu_divider #(.WIDTH(32)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: plain integer division; quotient truncates toward zero, remainder follows dividend.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                output logic [31:0] q, output logic [31:0] r, output logic dz);
    longint sa;
    longint sb;
    dz = (b == 32'd0);
    if (!s) begin
      if (b == 32'd0) begin
        q = 32'hFFFF_FFFF;
        r = a;
      end else begin
        q = a / b;
        r = a % b;
      end
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (b == 32'd0) begin
        q = (sa < 0) ? 32'd1 : 32'hFFFF_FFFF;
        r = a;
      end else begin
        q = 32'(sa / sb);
        r = 32'(sa % sb);
      end
    end
  endfunction

  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clk);
    dif.a     = a;
    dif.b     = b;
    dif.sign  = s;
    dif.start = 1'b1;
    @(posedge clk);
    #1;
    dif.start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (dif.done) begin
        cyc = i;
        return;
      end
    end
  endtask

  task automatic check_result(input string name, input logic [31:0] q, input logic [31:0] r,
                              input logic dz);
    check({name, ".quotient"}, dif.quotient, q);
    check({name, ".remainder"}, dif.remainder, r);
    check({name, ".div_by_zero"}, 32'(dif.div_by_zero), 32'(dz));
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [31:0] q, input logic [31:0] r, input logic dz,
                        input string name, input bit full);
    int cyc;
    launch(a, b, s);
    if (full) check({name, ".busy"}, 32'(dif.busy), 32'd1);
    wait_done(cyc);
    check({name, ".latency"}, 32'(cyc), 32'd33);
    check_result(name, q, r, dz);
    if (full) begin
      @(posedge clk);
      #1;
      check({name, ".done_pulse"}, 32'(dif.done), 32'd0);
      check({name, ".busy_after"}, 32'(dif.busy), 32'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1);
  end

  initial begin
    int          cyc;
    bit          seen_done;
    logic [31:0] ra, rb, eq, er;
    logic        rs, edz;

    n_checks = 0;
    n_fail   = 0;

    vecs[0]  = '{32'd100,       32'd7,         1'b0, 32'd14,        32'd2,         1'b0};
    vecs[1]  = '{32'hFFFF_FFF9, 32'd2,         1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0};
    vecs[2]  = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0,         1'b0};
    vecs[3]  = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0,         32'h8000_0000, 1'b0};
    vecs[4]  = '{32'h0000_1234, 32'd0,         1'b0, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1};
    vecs[5]  = '{32'h0000_1234, 32'd0,         1'b1, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1};
    vecs[6]  = '{32'hFFFF_FFF0, 32'd0,         1'b1, 32'd1,         32'hFFFF_FFF0, 1'b1};
    vecs[7]  = '{32'd7,         32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1,         1'b0};
    vecs[8]  = '{32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, 32'd3,         32'hFFFF_FFFF, 1'b0};
    vecs[9]  = '{32'd0,         32'd5,         1'b1, 32'd0,         32'd0,         1'b0};
    vecs[10] = '{32'hFFFF_FFFF, 32'd1,         1'b0, 32'hFFFF_FFFF, 32'd0,         1'b0};
    vecs[11] = '{32'd5,         32'hFFFF_FFFF, 1'b0, 32'd0,         32'd5,         1'b0};
    vecs[12] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'd1,         32'd0,         1'b0};

    rst_n     = 1'b0;
    dif.start = 1'b0;
    dif.sign  = 1'b0;
    dif.a     = '0;
    dif.b     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.busy", 32'(dif.busy), 32'd0);
    check("reset.done", 32'(dif.done), 32'd0);
    check_result("reset", 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].q, vecs[i].r, vecs[i].dz,
             $sformatf("vec%0d", i), 1'b1);
    end

    // Start pulse mid-CALC with new operands must be ignored.
    launch(32'd100, 32'd7, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    dif.a     = 32'd999;
    dif.b     = 32'd3;
    dif.sign  = 1'b1;
    dif.start = 1'b1;
    @(posedge clk);
    #1;
    dif.start = 1'b0;
    wait_done(cyc);
    check("ignore.latency", 32'(cyc), 32'd22);
    check_result("ignore", 32'd14, 32'd2, 1'b0);

    // Back-to-back: start raised during the done cycle.
    dif.a     = 32'd1000;
    dif.b     = 32'd10;
    dif.sign  = 1'b0;
    dif.start = 1'b1;
    @(posedge clk);
    #1;
    dif.start = 1'b0;
    check("b2b.busy", 32'(dif.busy), 32'd1);
    check_result("b2b.hold", 32'd14, 32'd2, 1'b0);
    wait_done(cyc);
    check("b2b.latency", 32'(cyc), 32'd33);
    check_result("b2b", 32'd100, 32'd0, 1'b0);

    // Asynchronous reset in the middle of CALC.
    launch(32'hFFFF_FFF9, 32'd2, 1'b1);
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("abort.busy", 32'(dif.busy), 32'd0);
    check("abort.done", 32'(dif.done), 32'd0);
    check_result("abort", 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (dif.done) seen_done = 1'b1;
    end
    check("abort.no_done", 32'(seen_done), 32'd0);
    run_op(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, "after_abort", 1'b1);

    for (int i = 0; i < 1200; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
        default: rb = $urandom;
      endcase
      rs = 1'($urandom_range(0, 1));
      model(ra, rb, rs, eq, er, edz);
      run_op(ra, rb, rs, eq, er, edz, $sformatf("rnd%0d", i), 1'b0);
      if (rb != 32'd0)
        check($sformatf("rnd%0d.identity", i), dif.quotient * rb + dif.remainder, ra);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
